// File: rtl/multi_core_cpu.sv
// multi_core_cpu: two independent single-cycle register-machine cores with private ROMs
// Optional feature macro: SECOND_CORE_EN (defined: core 1 present; undefined: result2/carry2 tied to 0)
// Ports:
//   sys_clk  in   single clock, all state updates on rising edge
//   reset    in   synchronous active-high reset
//   carry    out  core 0 carry/borrow flag
//   carry2   out  core 1 carry/borrow flag
//   result   out  core 0 output register (DATA_SIZE)
//   result2  out  core 1 output register (DATA_SIZE)
module mcc_core #(
    parameter int DATA_SIZE = 32,
    parameter int MEM_SIZE  = 8,
    parameter int CORE_ID   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 carry_o,
    output logic [DATA_SIZE-1:0] result_o
);
    localparam int PW = $clog2(MEM_SIZE);
    localparam logic [15:0] ROM0 [8] = '{16'h1005, 16'h1407, 16'h2100, 16'h7000,
                                         16'h3400, 16'h7400, 16'hF000, 16'h0000};
    localparam logic [15:0] ROM1 [8] = '{16'h1003, 16'h8004, 16'h7000, 16'h1402,
                                         16'h2100, 16'h7000, 16'h9004, 16'h0000};
    logic [PW-1:0]        pc_q, pc_d;
    logic [DATA_SIZE-1:0] r_q [4];
    logic [DATA_SIZE-1:0] r_d [4];
    logic                 carry_q, carry_d, halted_q, halted_d;
    logic [DATA_SIZE-1:0] result_q, result_d;
    logic [15:0]          instr;
    logic [3:0]           op;
    logic [1:0]           rd, rs;
    logic [DATA_SIZE-1:0] imm, a, b;
    logic [DATA_SIZE:0]   sum;
    // ROM slots past index 7 read as NOP when MEM_SIZE is larger
    assign instr = (32'(pc_q) < 32'd8) ? (CORE_ID == 0 ? ROM0[pc_q[2:0]] : ROM1[pc_q[2:0]]) : 16'h0000;
    assign op    = instr[15:12];
    assign rd    = instr[11:10];
    assign rs    = instr[9:8];
    assign imm   = DATA_SIZE'(instr[7:0]);
    assign a     = r_q[rd];
    assign b     = (op == 4'h8) ? imm : r_q[rs];
    assign sum   = {1'b0, a} + {1'b0, b};
    always_comb begin
        pc_d     = halted_q ? pc_q : pc_q + 1'b1;
        r_d      = r_q;
        carry_d  = carry_q;
        result_d = result_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (op)
                4'h1: r_d[rd] = imm;
                4'h2, 4'h8: {carry_d, r_d[rd]} = sum;
                4'h3: begin
                    r_d[rd] = a - b;
                    carry_d = a < b;
                end
                4'h4: r_d[rd] = a & b;
                4'h5: r_d[rd] = a | b;
                4'h6: r_d[rd] = a ^ b;
                4'h7: result_d = a;
                4'h9: pc_d = instr[PW-1:0];
                4'hF: begin
                    pc_d     = pc_q;
                    halted_d = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= '0;
            r_q      <= '{default: '0};
            carry_q  <= 1'b0;
            result_q <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            r_q      <= r_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            halted_q <= halted_d;
        end
    end
    assign carry_o  = carry_q;
    assign result_o = result_q;
endmodule

module multi_core_cpu #(
    parameter int DATA_SIZE = 32,
    parameter int MEM_SIZE  = 8
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    output logic                 carry,
    output logic                 carry2,
    output logic [DATA_SIZE-1:0] result,
    output logic [DATA_SIZE-1:0] result2
);
    mcc_core #(.DATA_SIZE(DATA_SIZE), .MEM_SIZE(MEM_SIZE), .CORE_ID(0)) u_core0 (
        .clk_i(sys_clk), .rst_i(reset), .carry_o(carry), .result_o(result)
    );
`ifdef SECOND_CORE_EN
    mcc_core #(.DATA_SIZE(DATA_SIZE), .MEM_SIZE(MEM_SIZE), .CORE_ID(1)) u_core1 (
        .clk_i(sys_clk), .rst_i(reset), .carry_o(carry2), .result_o(result2)
    );
`else
    assign carry2  = 1'b0;
    assign result2 = '0;
`endif
endmodule

// File: tb/tb_multi_core_cpu.sv
// tb_multi_core_cpu: directed self-checking bench for multi_core_cpu (32-bit and 8-bit builds)
module tb_multi_core_cpu;
    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        rst8    = 1'b1;
    logic        carry, carry2, carry_8, carry2_8;
    logic [31:0] result, result2;
    logic [7:0]  result_8, result2_8;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 sys_clk = ~sys_clk;

    multi_core_cpu #(.DATA_SIZE(32), .MEM_SIZE(8)) dut (
        .sys_clk(sys_clk), .reset(reset), .carry(carry), .carry2(carry2),
        .result(result), .result2(result2)
    );
    multi_core_cpu #(.DATA_SIZE(8), .MEM_SIZE(8)) dut8 (
        .sys_clk(sys_clk), .reset(rst8), .carry(carry_8), .carry2(carry2_8),
        .result(result_8), .result2(result2_8)
    );

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] exp_res(input int e);
        return e >= 6 ? 32'hFFFF_FFFB : e >= 4 ? 32'd12 : 32'd0;
    endfunction

    function automatic logic exp_c(input int e);
        return e >= 5;
    endfunction

    function automatic logic [31:0] exp_res2(input int e);
`ifdef SECOND_CORE_EN
        return e < 3 ? 32'd0 : e < 6 ? 32'd7 : 32'(9 + 2 * ((e - 6) / 3));
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        step(4);
        n_cmp += 4;
        if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        if (result2 !== 32'd0) begin n_err++; $display("FAIL reset_result2 got %h want 0", result2); end
        if (carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b want 0", carry); end
        if (carry2 !== 1'b0) begin n_err++; $display("FAIL reset_carry2 got %b want 0", carry2); end
    endtask

    task automatic test_core0;
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step(1);
            n_cmp += 3;
            if (result !== exp_res(e)) begin n_err++; $display("FAIL core0_result e=%0d got %h want %h", e, result, exp_res(e)); end
            if (carry !== exp_c(e)) begin n_err++; $display("FAIL core0_carry e=%0d got %b want %b", e, carry, exp_c(e)); end
            if (result2 !== exp_res2(e)) begin n_err++; $display("FAIL core1_result e=%0d got %h want %h", e, result2, exp_res2(e)); end
        end
    endtask

    task automatic test_long_run;
        for (int e = 7; e <= 46; e++) begin
            step(1);
            n_cmp += 4;
            if (result !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL halt_result e=%0d got %h want fffffffb", e, result); end
            if (carry !== 1'b1) begin n_err++; $display("FAIL halt_carry e=%0d got %b want 1", e, carry); end
            if (result2 !== exp_res2(e)) begin n_err++; $display("FAIL run_result2 e=%0d got %h want %h", e, result2, exp_res2(e)); end
            if (carry2 !== 1'b0) begin n_err++; $display("FAIL run_carry2 e=%0d got %b want 0", e, carry2); end
        end
    endtask

    task automatic test_mid_reset;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(10);
        n_cmp += 2;
        if (result2 !== exp_res2(10)) begin n_err++; $display("FAIL e10_result2 got %h want %h", result2, exp_res2(10)); end
        if (result !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL e10_result got %h want fffffffb", result); end
        reset = 1'b1;
        step(1);
        n_cmp += 4;
        if (result !== 32'd0) begin n_err++; $display("FAIL mid_reset_result got %h want 0", result); end
        if (result2 !== 32'd0) begin n_err++; $display("FAIL mid_reset_result2 got %h want 0", result2); end
        if (carry !== 1'b0) begin n_err++; $display("FAIL mid_reset_carry got %b want 0", carry); end
        if (carry2 !== 1'b0) begin n_err++; $display("FAIL mid_reset_carry2 got %b want 0", carry2); end
        reset = 1'b0;
        step(3);
        n_cmp += 2;
        if (result2 !== exp_res2(3)) begin n_err++; $display("FAIL restart_result2 got %h want %h", result2, exp_res2(3)); end
        if (result !== 32'd0) begin n_err++; $display("FAIL restart_result got %h want 0", result); end
        step(1);
        n_cmp += 1;
        if (result !== 32'd12) begin n_err++; $display("FAIL restart_e4_result got %h want 0000000c", result); end
    endtask

    task automatic test_width8;
        logic [7:0] w375, w378, w381;
        logic       c377, c378, c380;
`ifdef SECOND_CORE_EN
        w375 = 8'hFF; w378 = 8'h01; w381 = 8'h03;
        c377 = 1'b1;  c378 = 1'b1;  c380 = 1'b0;
`else
        w375 = 8'h00; w378 = 8'h00; w381 = 8'h00;
        c377 = 1'b0;  c378 = 1'b0;  c380 = 1'b0;
`endif
        rst8 = 1'b1;
        step(2);
        rst8 = 1'b0;
        step(6);
        n_cmp += 2;
        if (result_8 !== 8'hFB) begin n_err++; $display("FAIL w8_result got %h want fb", result_8); end
        if (carry_8 !== 1'b1) begin n_err++; $display("FAIL w8_carry got %b want 1", carry_8); end
        step(369);
        n_cmp += 2;
        if (result2_8 !== w375) begin n_err++; $display("FAIL w8_e375_result2 got %h want %h", result2_8, w375); end
        if (carry2_8 !== 1'b0) begin n_err++; $display("FAIL w8_e375_carry2 got %b want 0", carry2_8); end
        step(2);
        n_cmp += 1;
        if (carry2_8 !== c377) begin n_err++; $display("FAIL w8_e377_carry2 got %b want %b", carry2_8, c377); end
        step(1);
        n_cmp += 2;
        if (result2_8 !== w378) begin n_err++; $display("FAIL w8_e378_result2 got %h want %h", result2_8, w378); end
        if (carry2_8 !== c378) begin n_err++; $display("FAIL w8_e378_carry2 got %b want %b", carry2_8, c378); end
        step(2);
        n_cmp += 1;
        if (carry2_8 !== c380) begin n_err++; $display("FAIL w8_e380_carry2 got %b want %b", carry2_8, c380); end
        step(1);
        n_cmp += 2;
        if (result2_8 !== w381) begin n_err++; $display("FAIL w8_e381_result2 got %h want %h", result2_8, w381); end
        if (result_8 !== 8'hFB) begin n_err++; $display("FAIL w8_halt_result got %h want fb", result_8); end
    endtask

    initial begin
        test_reset;
        test_core0;
        test_long_run;
        test_mid_reset;
        test_width8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
